// File: rtl/uart_pkg.sv
`timescale 1ns/1ps
// Shared UART definitions: receiver/transmitter state encoding, frame shape
// and the clock-to-baud divider helper used by both directions of the link.
package uart_pkg;

   localparam int DATA_BITS = 8;
   localparam int STOP_BITS = 1;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      BREAK
   } uart_state_e;

   // Number of system clock cycles per serial bit (truncating division).
   function automatic int bit_cycles(input int clk_freq, input int baud);
      return clk_freq / baud;
   endfunction

endpackage

// File: rtl/uart_sync2.sv
`timescale 1ns/1ps
// Generic two-flop synchroniser for an asynchronous single-bit input.
// The reset value is a parameter so idle-high and idle-low pins can share it.
module uart_sync2 #(
   parameter logic RESET_VAL = 1'b1
) (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic meta_q, meta_d;
   logic sync_q, sync_d;

   // Next values are simply the previous stage of the chain.
   always_comb begin
      meta_d = d;
      sync_d = meta_q;
   end

   // Both stages fall back to the idle level while reset is held low.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         meta_q <= RESET_VAL;
         sync_q <= RESET_VAL;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
`timescale 1ns/1ps
// UART receiver: 8N1, LSB first, idle-high line. Samples each bit at its
// centre, strobes rx_valid for one cycle per good frame, flags framing errors
// and ignores start glitches shorter than half a bit.
module uart_rx
   import uart_pkg::*;
#(
   parameter int CLK_FREQ  = 50_000_000,
   parameter int BAUD_RATE = 9600
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rx,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       rx_busy,
   output logic       rx_frame_err
);

   localparam int BIT_CYCLES  = bit_cycles(CLK_FREQ, BAUD_RATE);
   localparam int HALF_CYCLES = BIT_CYCLES / 2;
   localparam int CNT_W       = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;

   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_CYCLES - 1);
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_CYCLES - 1);
   localparam logic [2:0]       IDX_LAST  = 3'(DATA_BITS - 1);

   logic rx_s;

   uart_state_e          state_q, state_d;
   logic [CNT_W-1:0]     baud_cnt_q, baud_cnt_d;
   logic [2:0]           bit_idx_q, bit_idx_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic [DATA_BITS-1:0] data_q, data_d;
   logic                 valid_q, valid_d;
   logic                 frame_err_q, frame_err_d;

   uart_sync2 #(
      .RESET_VAL (1'b1)
   ) u_sync (
      .clk   (clk),
      .reset (reset),
      .d     (rx),
      .q     (rx_s)
   );

   // Next-state, counter, shift register and strobe logic of the receive FSM.
   always_comb begin
      state_d     = state_q;
      baud_cnt_d  = baud_cnt_q + CNT_W'(1);
      bit_idx_d   = bit_idx_q;
      shift_d     = shift_q;
      data_d      = data_q;
      valid_d     = 1'b0;
      frame_err_d = 1'b0;

      case (state_q)
         IDLE: begin
            baud_cnt_d = '0;
            if (!rx_s) begin
               state_d = START;
            end
         end
         START: begin
            if (baud_cnt_q == HALF_LAST) begin
               if (!rx_s) begin
                  state_d   = DATA;
                  bit_idx_d = '0;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         DATA: begin
            if (baud_cnt_q == BIT_LAST) begin
               baud_cnt_d = '0;
               shift_d    = {rx_s, shift_q[DATA_BITS-1:1]};
               bit_idx_d  = bit_idx_q + 3'd1;
               if (bit_idx_q == IDX_LAST) begin
                  state_d = STOP;
               end
            end
         end
         STOP: begin
            if (baud_cnt_q == BIT_LAST) begin
               if (rx_s) begin
                  data_d  = shift_q;
                  valid_d = 1'b1;
                  state_d = IDLE;
               end else begin
                  frame_err_d = 1'b1;
                  state_d     = BREAK;
               end
            end
         end
         BREAK: begin
            baud_cnt_d = '0;
            if (rx_s) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d    = IDLE;
            baud_cnt_d = '0;
         end
      endcase

      if (state_d != state_q) begin
         baud_cnt_d = '0;
      end
   end

   // State and datapath registers; reset discards any partial frame.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         baud_cnt_q  <= '0;
         bit_idx_q   <= '0;
         shift_q     <= '0;
         data_q      <= '0;
         valid_q     <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         baud_cnt_q  <= baud_cnt_d;
         bit_idx_q   <= bit_idx_d;
         shift_q     <= shift_d;
         data_q      <= data_d;
         valid_q     <= valid_d;
         frame_err_q <= frame_err_d;
      end
   end

   assign rx_data      = data_q;
   assign rx_valid     = valid_q;
   assign rx_frame_err = frame_err_q;
   assign rx_busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
`timescale 1ns/1ps
// Directed bench for uart_rx at a reduced clock/baud ratio (50 cycles per bit)
// so that every scenario, including off-rate senders, runs in a few k cycles.
module tb_uart_rx;

   localparam int CLK_FREQ    = 5_000_000;
   localparam int BAUD_RATE   = 100_000;
   localparam int BIT         = CLK_FREQ / BAUD_RATE;
   localparam int HALF        = BIT / 2;
   localparam int LATENCY_EXP = 3 + HALF + 9 * BIT;

   logic       clk;
   logic       reset;
   logic       rx;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_busy;
   logic       rx_frame_err;

   int checks     = 0;
   int failures   = 0;
   int cycleCount = 0;
   int startCycle = 0;
   int validCycle = 0;
   int validCount = 0;
   int errCount   = 0;
   int bothCount  = 0;
   int longValid  = 0;
   int longErr    = 0;
   int busyMiss   = 0;
   bit busySeen   = 0;
   bit prevValid  = 0;
   bit prevErr    = 0;
   logic [7:0] rxQueue[$];

   uart_rx #(
      .CLK_FREQ  (CLK_FREQ),
      .BAUD_RATE (BAUD_RATE)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .rx           (rx),
      .rx_data      (rx_data),
      .rx_valid     (rx_valid),
      .rx_busy      (rx_busy),
      .rx_frame_err (rx_frame_err)
   );

   // 100 MHz-style free-running clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Cycle counter used for latency measurement.
   always @(posedge clk) cycleCount++;

   // Monitor: collects received bytes and pulse statistics on the falling edge.
   always @(negedge clk) begin
      if (reset) begin
         if (rx_valid) begin
            validCount++;
            rxQueue.push_back(rx_data);
            validCycle = cycleCount;
         end
         if (rx_frame_err) errCount++;
         if (rx_valid && rx_frame_err) bothCount++;
         if (rx_valid && prevValid) longValid++;
         if (rx_frame_err && prevErr) longErr++;
         if (rx_busy) busySeen = 1'b1;
      end
      prevValid = rx_valid;
      prevErr   = rx_frame_err;
   end

   // Watchdog so the run always ends even if the stimulus stalls.
   initial begin
      #500_000;
      $display("[TB] FAIL watchdog: observed timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         failures++;
         $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic checkNextByte(input string tag, input logic [7:0] expected);
      if (rxQueue.size() == 0) begin
         checkOutput(tag, 32'h1FF, {24'h0, expected});
      end else begin
         checkOutput(tag, {24'h0, rxQueue.pop_front()}, {24'h0, expected});
      end
   endtask

   // Drives one frame starting at the current falling edge; busy is sampled
   // in the middle of every data bit.
   task automatic applyStimulus(input logic [7:0] value, input int bitCycles,
                                input logic stopLevel);
      rx = 1'b0;
      startCycle = cycleCount;
      repeat (bitCycles) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx = value[i];
         repeat (bitCycles / 2) @(negedge clk);
         if (!rx_busy) busyMiss++;
         repeat (bitCycles - bitCycles / 2) @(negedge clk);
      end
      rx = stopLevel;
      repeat (bitCycles) @(negedge clk);
   endtask

   initial begin
      int v0;
      int e0;
      int lat;
      logic [7:0] b;

      reset = 1'b0;
      rx    = 1'b1;
      repeat (5) @(negedge clk);
      checkOutput("reset_data",  {24'h0, rx_data}, 32'h00);
      checkOutput("reset_valid", {31'h0, rx_valid}, 32'h0);
      checkOutput("reset_busy",  {31'h0, rx_busy}, 32'h0);
      checkOutput("reset_ferr",  {31'h0, rx_frame_err}, 32'h0);
      reset = 1'b1;
      repeat (10) @(negedge clk);

      // Single byte 0x55
      busyMiss = 0;
      applyStimulus(8'h55, BIT, 1'b1);
      repeat (BIT) @(negedge clk);
      checkOutput("single_count", validCount, 1);
      checkNextByte("single_data", 8'h55);
      checkOutput("single_ferr", errCount, 0);
      checkOutput("single_busy_miss", busyMiss, 0);
      lat = validCycle - startCycle;
      checkOutput("single_latency_ok",
                  {31'h0, (lat >= LATENCY_EXP - 3) && (lat <= LATENCY_EXP + 3)}, 32'h1);
      checkOutput("single_busy_after", {31'h0, rx_busy}, 32'h0);

      // Back-to-back 0xAA then 0x0F
      applyStimulus(8'hAA, BIT, 1'b1);
      applyStimulus(8'h0F, BIT, 1'b1);
      repeat (BIT) @(negedge clk);
      checkOutput("b2b_count", validCount, 3);
      checkNextByte("b2b_first", 8'hAA);
      checkNextByte("b2b_second", 8'h0F);
      checkOutput("b2b_ferr", errCount, 0);

      // Glitch shorter than half a bit
      busySeen = 1'b0;
      rx = 1'b0;
      repeat (HALF / 2) @(negedge clk);
      rx = 1'b1;
      repeat (3 * BIT) @(negedge clk);
      checkOutput("glitch_busy_seen", {31'h0, busySeen}, 32'h1);
      checkOutput("glitch_count", validCount, 3);
      checkOutput("glitch_ferr", errCount, 0);
      checkOutput("glitch_busy_after", {31'h0, rx_busy}, 32'h0);

      // Framing error: 0x3C with stop low, line held low for 2 more bits
      applyStimulus(8'h3C, BIT, 1'b0);
      repeat (2 * BIT) @(negedge clk);
      checkOutput("ferr_count", errCount, 1);
      checkOutput("ferr_no_valid", validCount, 3);
      checkOutput("ferr_data_kept", {24'h0, rx_data}, 32'h0F);
      checkOutput("ferr_break_busy", {31'h0, rx_busy}, 32'h1);
      rx = 1'b1;
      repeat (2 * BIT) @(negedge clk);
      checkOutput("ferr_release_idle", {31'h0, rx_busy}, 32'h0);
      applyStimulus(8'h81, BIT, 1'b1);
      repeat (BIT) @(negedge clk);
      checkNextByte("ferr_next_byte", 8'h81);
      checkOutput("ferr_count_after", errCount, 1);

      // Reset during data bit 4 of 0xC3, then 0x12
      v0 = validCount;
      b  = 8'hC3;
      rx = 1'b0;
      repeat (BIT) @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         rx = b[i];
         repeat (BIT) @(negedge clk);
      end
      rx = b[4];
      repeat (HALF) @(negedge clk);
      reset = 1'b0;
      rx    = 1'b1;
      repeat (3) @(negedge clk);
      checkOutput("mid_reset_data",  {24'h0, rx_data}, 32'h00);
      checkOutput("mid_reset_valid", {31'h0, rx_valid}, 32'h0);
      checkOutput("mid_reset_busy",  {31'h0, rx_busy}, 32'h0);
      checkOutput("mid_reset_ferr",  {31'h0, rx_frame_err}, 32'h0);
      reset = 1'b1;
      repeat (2 * BIT) @(negedge clk);
      checkOutput("mid_reset_no_valid", validCount, v0);
      applyStimulus(8'h12, BIT, 1'b1);
      repeat (BIT) @(negedge clk);
      checkOutput("post_reset_count", validCount, v0 + 1);
      checkNextByte("post_reset_byte", 8'h12);
      checkOutput("post_reset_data", {24'h0, rx_data}, 32'h12);

      // Sender running 2% slow and 2% fast, frames back to back
      e0 = errCount;
      for (int r = 0; r < 2; r++) begin
         int period;
         period = (r == 0) ? BIT + 1 : BIT - 1;
         for (int k = 0; k < 8; k++) begin
            b = 8'((k * 37 + 5 + r * 100) & 8'hFF);
            applyStimulus(b, period, 1'b1);
            checkNextByte($sformatf("tol_p%0d_k%0d", period, k), b);
         end
         repeat (2 * BIT) @(negedge clk);
      end
      checkOutput("tol_ferr", errCount, e0);

      checkOutput("never_both", bothCount, 0);
      checkOutput("valid_one_cycle", longValid, 0);
      checkOutput("ferr_one_cycle", longErr, 0);
      checkOutput("queue_drained", rxQueue.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/uart_rx.md
# uart_rx

UART receiver, companion to `uart_tx` on the same serial link: 8 data bits, no parity, 1 stop bit, LSB first, idle-high line. It synchronises the asynchronous `rx` pin, detects a start bit, samples each bit at its centre using a clock-divided baud counter, and presents the received byte with a one-cycle valid strobe. It flags framing errors and rejects glitches shorter than half a bit.

## Interface
- `CLK_FREQ`, default 50_000_000: system clock frequency in Hz.
- `BAUD_RATE`, default 9600: line rate in bit/s.
- `BIT_CYCLES` (localparam): CLK_FREQ / BAUD_RATE with integer truncation; 5208 at defaults.
- `HALF_CYCLES` (localparam): BIT_CYCLES / 2; 2604 at defaults.
- `clk  input  1`: system clock, rising edge.
- `reset  input  1`: asynchronous, active-low reset. 0 means in reset.
- `rx  input  1`: serial line, asynchronous to `clk`, idle high.
- `rx_data  output  8`: last correctly framed byte; held until the next good frame.
- `rx_valid  output  1`: one-cycle pulse, `rx_data` newly updated.
- `rx_busy  output  1`: high whenever the FSM is not in IDLE.
- `rx_frame_err  output  1`: one-cycle pulse when the stop bit is sampled low.

## Operation
- **Input synchroniser:** `rx` passes through 2 flops, giving `rx_s`. Both flops reset to 1. The FSM only ever looks at `rx_s`.
- **Counters:**
  - `baud_cnt` is wide enough for BIT_CYCLES-1 and is cleared on every state change.
  - `bit_idx` is 3 bits.
- **FSM states:**
  - **IDLE:** when `rx_s==0`, go to START.
  - **START:** count to HALF_CYCLES-1, then sample `rx_s`.
    - If 0: go to DATA with `bit_idx=0`.
    - If 1: treat as a glitch and return to IDLE. No flags are raised.
  - **DATA:** at `baud_cnt==BIT_CYCLES-1`, shift `rx_s` into the MSB of the shift register (shift right), then increment `bit_idx`. After the sample taken at `bit_idx==7`, go to STOP.
  - **STOP:** at `baud_cnt==BIT_CYCLES-1`, sample `rx_s`.
    - If 1: load `rx_data` from the shift register, pulse `rx_valid`, go to IDLE.
    - If 0: pulse `rx_frame_err`, leave `rx_data` unchanged, go to BREAK.
  - **BREAK:** wait for `rx_s==1`, then go to IDLE. This handles a break or stuck-low line without generating false starts.
- **Sample point:** the FSM returns to IDLE at the centre of the stop bit, so a start bit immediately after the stop bit is caught. Back-to-back frames are supported.
- **Reset mid-frame:** asynchronous. The FSM returns to IDLE, counters and shift register clear, and the synchroniser flops go to 1. The partial byte is discarded with no `rx_valid`.
- `rx_valid` and `rx_frame_err` are never high in the same cycle.

## Timing
- **Reset values:** `rx_data=8'h00`, `rx_valid=0`, `rx_busy=0`, `rx_frame_err=0`, FSM in IDLE.
- **Start detection:** 2 cycles of synchroniser latency plus 1 cycle for IDLE→START. `rx_busy` rises on the cycle the FSM enters START.
- **Bit sampling:** start is sampled HALF_CYCLES after entering START. Data bit n is sampled (n+1)·BIT_CYCLES after that. Stop is sampled 9·BIT_CYCLES after the start sample.
- **Output latency:** `rx_valid` / `rx_frame_err` are registered and go high in the cycle after the stop-sample edge, for exactly 1 cycle. `rx_busy` falls in the same cycle.
- **Total latency:** from the synchronised falling edge to `rx_valid` is about HALF_CYCLES + 9·BIT_CYCLES + 2 cycles (≈49,478 cycles at defaults). The bench checks this within ±3 cycles.
- **Tolerance:** baud mismatch up to ±2% must still decode correctly.

## Structure
- **Shared package `uart_pkg`:**
  - FSM state enum (IDLE, START, DATA, STOP, BREAK).
  - Frame constants: `DATA_BITS=8`, `STOP_BITS=1`.
  - Function `bit_cycles(clk_freq, baud)`.
  - `uart_tx` is to be migrated onto the same package.
- **Sub-module `uart_sync2`:** generic 2-flop synchroniser with a reset-value parameter (1 here). It is reused later for the CTS/RTS pins.
- Everything else lives in `uart_rx`. Expected size is about 150–200 RTL lines.

## Test plan
- **Single byte:** drive frame 0x55 at 9600 baud. Expect `rx_valid` pulse of 1 cycle, `rx_data==8'h55`, `rx_frame_err==0`, `rx_busy` high throughout the frame.
- **Back-to-back:** send 0xAA immediately followed by 0x0F, with no idle between stop and start. Expect two `rx_valid` pulses carrying 0xAA then 0x0F, with no framing error.
- **Glitch:** pulse `rx` low for 1000 cycles (< HALF_CYCLES). Expect `rx_busy` to pulse, then the FSM returns to IDLE with no `rx_valid` and no `rx_frame_err`.
- **Framing error:** send 0x3C with the stop bit forced low, then hold the line low for 2 bit times and release. Expect one `rx_frame_err` pulse, `rx_data` keeps its previous value, no new start detected until the line goes high, then a following 0x81 is received correctly.
- **Reset mid-frame:** assert `reset=0` during data bit 4 of 0xC3, release, then send 0x12. Expect all outputs at reset values during reset, no `rx_valid` for the aborted byte, then `rx_data==8'h12`.
- **Loopback:** `uart_tx.tx` drives `uart_rx.rx`, with 256 bytes 0x00–0xFF sent through `uart_tx`. Expect every byte received in order with no errors. Repeat with the receiver's BAUD_RATE at 9792 (+2%): still error-free.
